// File: rtl/pool_relu_nch.sv
// pool_relu_nch
//   Streaming POOLxPOOL (stride POOL) max/average pooling with optional ReLU,
//   applied independently to CH parallel signed channels arriving one raster
//   pixel per valid cycle. One pooled result is emitted per completed window.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous reset, active low
//   valid_in    data_in carries a pixel this cycle
//   sof         with valid_in: this pixel is row 0, col 0 (resyncs counters)
//   mode_avg    0 = max pooling, 1 = average pooling (latched at frame start)
//   relu_en     1 = clamp negative results to 0 (latched at frame start)
//   data_in     CH signed samples, channel c at [c*DATA_BIT +: DATA_BIT]
//   data_out    CH pooled results, same packing, held between pulses
//   valid_out   one-cycle pulse per completed window
//   frame_done  high together with valid_out on the last window of a frame
module pool_relu_nch #(
    parameter int CH        = 3,
    parameter int DATA_BIT  = 12,
    parameter int IN_WIDTH  = 24,
    parameter int IN_HEIGHT = 24,
    parameter int POOL      = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_in,
    input  logic                   sof,
    input  logic                   mode_avg,
    input  logic                   relu_en,
    input  logic [CH*DATA_BIT-1:0] data_in,
    output logic [CH*DATA_BIT-1:0] data_out,
    output logic                   valid_out,
    output logic                   frame_done
);

    localparam int LOG2P    = (POOL == 4) ? 2 : 1;
    localparam int SHIFT    = 2 * LOG2P;
    localparam int EW       = DATA_BIT + SHIFT;
    localparam int NENT     = IN_WIDTH / POOL;
    localparam int OUT_ROWS = IN_HEIGHT / POOL;
    localparam int CW       = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int IW       = (NENT > 1) ? $clog2(NENT) : 1;
    localparam int RW       = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;

    localparam logic [CW-1:0]    COL_LAST = CW'(IN_WIDTH - 1);
    localparam logic [LOG2P-1:0] WIN_LAST = {LOG2P{1'b1}};
    localparam logic [RW-1:0]    ROW_LAST = RW'(OUT_ROWS - 1);

    if (!(POOL == 2 || POOL == 4)) begin : g_bad_pool
        $error("pool_relu_nch: POOL must be 2 or 4");
    end
    if ((IN_WIDTH % POOL) != 0 || (IN_HEIGHT % POOL) != 0) begin : g_bad_size
        $error("pool_relu_nch: IN_WIDTH and IN_HEIGHT must be multiples of POOL");
    end

    logic [CW-1:0]    col;
    logic [LOG2P-1:0] win_row;
    logic [RW-1:0]    out_row;
    logic             mode_q;
    logic             relu_q;

    // Entries hold a sign-extended running max or a running sum per window column.
    logic signed [EW-1:0] lbuf [CH][NENT];

    logic [CW-1:0]    eff_col, col_n;
    logic [LOG2P-1:0] eff_win, win_n;
    logic [RW-1:0]    eff_orow, orow_n;
    logic             frame_start, avg_now, relu_now, first, last, frame_last;
    logic [IW-1:0]    idx;

    // sof zeroes the position before the pixel is used, so the same pixel
    // both starts the frame and samples mode/relu.
    always_comb begin
        eff_col     = sof ? '0 : col;
        eff_win     = sof ? '0 : win_row;
        eff_orow    = sof ? '0 : out_row;
        frame_start = (eff_col == '0) && (eff_win == '0) && (eff_orow == '0);
        avg_now     = frame_start ? mode_avg : mode_q;
        relu_now    = frame_start ? relu_en  : relu_q;
        first       = (eff_win == '0) && (eff_col[LOG2P-1:0] == '0);
        last        = (eff_win == WIN_LAST) && (eff_col[LOG2P-1:0] == WIN_LAST);
        frame_last  = (eff_orow == ROW_LAST) && (eff_col == COL_LAST);
        idx         = IW'(eff_col >> LOG2P);

        col_n  = eff_col + 1'b1;
        win_n  = eff_win;
        orow_n = eff_orow;
        if (eff_col == COL_LAST) begin
            col_n = '0;
            if (eff_win == WIN_LAST) begin
                win_n  = '0;
                orow_n = (eff_orow == ROW_LAST) ? '0 : eff_orow + 1'b1;
            end else begin
                win_n = eff_win + 1'b1;
            end
        end
    end

    logic signed [EW-1:0]    nxt_entry [CH];
    logic [CH*DATA_BIT-1:0]  result_bus;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic signed [DATA_BIT-1:0] smp, ent_lo, mx, res;
        logic signed [EW-1:0]       smp_ext, ent, sum, nxt;

        always_comb begin
            smp     = data_in[c*DATA_BIT +: DATA_BIT];
            smp_ext = {{SHIFT{smp[DATA_BIT-1]}}, smp};
            ent     = lbuf[c][idx];
            ent_lo  = ent[DATA_BIT-1:0];
            sum     = ent + smp_ext;
            mx      = (ent_lo > smp) ? ent_lo : smp;
            // The last sample is folded in combinationally; the sum of a full
            // window shifted right by 2*log2(POOL) always fits DATA_BIT.
            res     = avg_now ? DATA_BIT'(sum >>> SHIFT) : mx;
            if (relu_now && res[DATA_BIT-1]) begin
                res = '0;
            end
            if (first) begin
                nxt = smp_ext;
            end else if (avg_now) begin
                nxt = sum;
            end else begin
                nxt = {{SHIFT{mx[DATA_BIT-1]}}, mx};
            end
        end

        assign nxt_entry[c]                           = nxt;
        assign result_bus[c*DATA_BIT +: DATA_BIT]     = res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            win_row    <= '0;
            out_row    <= '0;
            mode_q     <= 1'b0;
            relu_q     <= 1'b0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                for (int e = 0; e < NENT; e++) begin
                    lbuf[c][e] <= '0;
                end
            end
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            if (valid_in) begin
                for (int c = 0; c < CH; c++) begin
                    lbuf[c][idx] <= nxt_entry[c];
                end
                if (frame_start) begin
                    mode_q <= mode_avg;
                    relu_q <= relu_en;
                end
                if (last) begin
                    data_out   <= result_bus;
                    valid_out  <= 1'b1;
                    frame_done <= frame_last;
                end
                col     <= col_n;
                win_row <= win_n;
                out_row <= orow_n;
            end
        end
    end

endmodule

// File: tb/tb_pool_relu_nch.sv
// tb_pool_relu_nch
//   Directed bench for pool_relu_nch. dut2: POOL=2 on a 4x4 frame, dut4:
//   POOL=4 on an 8x8 ramp frame; both CH=3, DATA_BIT=12, shared clock/reset.
module tb_pool_relu_nch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        d2_valid, d2_sof, d2_mode, d2_relu, d2_vout, d2_fd;
    logic [35:0] d2_in, d2_out;
    logic        d4_valid, d4_sof, d4_mode, d4_relu, d4_vout, d4_fd;
    logic [35:0] d4_in, d4_out;

    pool_relu_nch #(.CH(3), .DATA_BIT(12), .IN_WIDTH(4), .IN_HEIGHT(4), .POOL(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .valid_in(d2_valid), .sof(d2_sof),
        .mode_avg(d2_mode), .relu_en(d2_relu), .data_in(d2_in),
        .data_out(d2_out), .valid_out(d2_vout), .frame_done(d2_fd));

    pool_relu_nch #(.CH(3), .DATA_BIT(12), .IN_WIDTH(8), .IN_HEIGHT(8), .POOL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .valid_in(d4_valid), .sof(d4_sof),
        .mode_avg(d4_mode), .relu_en(d4_relu), .data_in(d4_in),
        .data_out(d4_out), .valid_out(d4_vout), .frame_done(d4_fd));

    int checks   = 0;
    int failures = 0;

    // 4x4 frame, raster order. ch1 is the negation of ch0.
    int f2c0 [16] = '{-5, 3, -4, -2,  7, -1, -9, -3,  1, 2, -1, -1,  3, 5, -1, -2};
    int f2c2 [16] = '{2047, 2047, -2048, -2048,  2047, 2047, -2048, -2048,
                      2047, -2048, 0, 0,  0, 0, 0, 0};

    // Expected per window w (order of completion) and channel c at [w*3+c].
    // sel 0: max+relu, 1: max, 2: avg, 3: avg+relu
    int e2 [4][12] = '{
        '{7, 5, 2047,   0, 9, 0,        5, 0, 2047,    0, 2, 0},
        '{7, 5, 2047,  -2, 9, -2048,    5, -1, 2047,  -1, 2, 0},
        '{1, -1, 2047, -5, 4, -2048,    2, -3, -1,    -2, 1, 0},
        '{1, 0, 2047,   0, 4, 0,        2, 0, 0,       0, 1, 0}};

    // 8x8 ramp, average of each 4x4 window, windows in completion order.
    int e4 [4][3] = '{'{-19, 405, -346}, '{-15, 525, -478},
                      '{13, 1365, -1402}, '{17, 1485, -1534}};

    function automatic int ramp(input int ch, input int i);
        if (ch == 0) return i - 32;
        if (ch == 1) return i * 30;
        return 100 - 33 * i;
    endfunction

    task automatic run_frame2(input bit avg, input bit relu, input bit first_sof,
                              input int toggle_at, input int sel, input string tag);
        int w, got;
        d2_mode = avg;
        d2_relu = relu;
        for (int i = 0; i < 16; i++) begin
            if (i == toggle_at) begin
                d2_mode = ~avg;
                d2_relu = ~relu;
            end
            d2_in    = {12'(f2c2[i]), 12'(-f2c0[i]), 12'(f2c0[i])};
            d2_valid = 1'b1;
            d2_sof   = first_sof && (i == 0);
            @(posedge clk);
            #1;
            d2_valid = 1'b0;
            d2_sof   = 1'b0;
            w = (i == 5) ? 0 : (i == 7) ? 1 : (i == 13) ? 2 : (i == 15) ? 3 : -1;
            checks++;
            if (d2_vout !== (w >= 0)) begin
                failures++;
                $display("FAIL %s valid px%0d: got %b want %b", tag, i, d2_vout, w >= 0);
            end
            checks++;
            if (d2_fd !== (w == 3)) begin
                failures++;
                $display("FAIL %s frame_done px%0d: got %b want %b", tag, i, d2_fd, w == 3);
            end
            if (w >= 0) begin
                for (int c = 0; c < 3; c++) begin
                    got = int'($signed(d2_out[c*12 +: 12]));
                    checks++;
                    if (got !== e2[sel][w*3+c]) begin
                        failures++;
                        $display("FAIL %s data w%0d ch%0d: got %0d want %0d",
                                 tag, w, c, got, e2[sel][w*3+c]);
                    end
                end
            end
        end
    endtask

    task automatic run_frame4(input int max_gap, input bit first_sof, input string tag);
        int r, c, w, got, pulses, gap;
        bit lastpx;
        pulses  = 0;
        d4_mode = 1'b1;
        d4_relu = 1'b0;
        for (int i = 0; i < 64; i++) begin
            d4_in    = {12'(ramp(2, i)), 12'(ramp(1, i)), 12'(ramp(0, i))};
            d4_valid = 1'b1;
            d4_sof   = first_sof && (i == 0);
            @(posedge clk);
            #1;
            d4_valid = 1'b0;
            d4_sof   = 1'b0;
            r = i / 8;
            c = i % 8;
            lastpx = (r % 4 == 3) && (c % 4 == 3);
            w = (r / 4) * 2 + c / 4;
            if (d4_vout) pulses++;
            checks++;
            if (d4_vout !== lastpx) begin
                failures++;
                $display("FAIL %s valid px%0d: got %b want %b", tag, i, d4_vout, lastpx);
            end
            if (lastpx) begin
                checks++;
                if (d4_fd !== (w == 3)) begin
                    failures++;
                    $display("FAIL %s frame_done w%0d: got %b want %b", tag, w, d4_fd, w == 3);
                end
                for (int k = 0; k < 3; k++) begin
                    got = int'($signed(d4_out[k*12 +: 12]));
                    checks++;
                    if (got !== e4[w][k]) begin
                        failures++;
                        $display("FAIL %s data w%0d ch%0d: got %0d want %0d",
                                 tag, w, k, got, e4[w][k]);
                    end
                end
            end
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                @(posedge clk);
                #1;
                checks++;
                if (d4_vout !== 1'b0 || d4_fd !== 1'b0) begin
                    failures++;
                    $display("FAIL %s idle after px%0d: got valid=%b fd=%b want 0 0",
                             tag, i, d4_vout, d4_fd);
                end
            end
        end
        checks++;
        if (pulses !== 4) begin
            failures++;
            $display("FAIL %s pulse_count: got %0d want 4", tag, pulses);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        d2_valid = 1'b0; d2_sof = 1'b0; d2_mode = 1'b0; d2_relu = 1'b0; d2_in = '0;
        d4_valid = 1'b0; d4_sof = 1'b0; d4_mode = 1'b0; d4_relu = 1'b0; d4_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (d2_out !== '0 || d2_vout !== 1'b0 || d2_fd !== 1'b0) begin
            failures++;
            $display("FAIL reset dut2: got out=%h v=%b fd=%b want 0", d2_out, d2_vout, d2_fd);
        end
        checks++;
        if (d4_out !== '0 || d4_vout !== 1'b0 || d4_fd !== 1'b0) begin
            failures++;
            $display("FAIL reset dut4: got out=%h v=%b fd=%b want 0", d4_out, d4_vout, d4_fd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_max_relu();
        run_frame2(1'b0, 1'b1, 1'b1, -1, 0, "max_relu");
    endtask

    task automatic test_max_avg();
        run_frame2(1'b0, 1'b0, 1'b0, -1, 1, "max_norelu");
        run_frame2(1'b1, 1'b0, 1'b1, -1, 2, "avg_norelu");
        run_frame2(1'b1, 1'b1, 1'b0, -1, 3, "avg_relu");
    endtask

    task automatic test_mode_toggle();
        run_frame2(1'b0, 1'b0, 1'b0, 4, 1, "toggle_cur");
        run_frame2(1'b1, 1'b1, 1'b0, -1, 3, "toggle_next");
    endtask

    task automatic test_sof_resync();
        d2_mode = 1'b1;
        d2_relu = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d2_in    = {3{12'd2000}};
            d2_valid = 1'b1;
            @(posedge clk);
            #1;
            d2_valid = 1'b0;
        end
        run_frame2(1'b0, 1'b1, 1'b1, -1, 0, "sof_resync");
    endtask

    task automatic test_pool4_continuous();
        run_frame4(0, 1'b1, "pool4_cont");
    endtask

    task automatic test_pool4_gaps();
        run_frame4(5, 1'b0, "pool4_gaps");
    endtask

    task automatic test_reset_mid_frame();
        d4_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d4_in    = {12'(ramp(2, i + 7)), 12'(ramp(1, i + 3)), 12'(ramp(0, i))};
            d4_valid = 1'b1;
            d4_sof   = (i == 0);
            if (i < 3) begin
                d2_in    = {3{12'd1500}};
                d2_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            d4_valid = 1'b0;
            d4_sof   = 1'b0;
            d2_valid = 1'b0;
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (d4_out !== '0 || d4_vout !== 1'b0 || d4_fd !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid dut4: got out=%h v=%b fd=%b want 0", d4_out, d4_vout, d4_fd);
        end
        checks++;
        if (d2_out !== '0) begin
            failures++;
            $display("FAIL rst_mid dut2: got out=%h want 0", d2_out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame4(0, 1'b0, "post_rst4");
        run_frame2(1'b0, 1'b0, 1'b0, -1, 1, "post_rst2");
    endtask

    initial begin
        test_reset();
        test_max_relu();
        test_max_avg();
        test_mode_toggle();
        test_sof_resync();
        test_pool4_continuous();
        test_pool4_gaps();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
